mdr_driver: RTL
===============

# mdr_driver

Command-side sequencer for the multiply/divide/root unit (`top_mdr`). It accepts one arithmetic command (op plus two operands) over a valid/ready handshake and drives the MDR operand interface: two `load` strobes with data, then one `start` strobe. It then waits a fixed latency, captures `result`/`remainder`, and returns them over a valid/ready response handshake. It sits between the system command path and `top_mdr`; it is the initiator of the protocol that `top_mdr` receives.

## Interface
Parameters:
- `DW`, default `Pkg_Global::N`: operand/result width.
- `WAIT_CYC`, default `DW+2`: cycles waited after the `start` strobe before capture. Must be ≥ 1.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  driver idle, can accept a command.
- `cmd_op`  in  2  0 = multiply, 1 = divide, 2 = square root, 3 = reserved.
- `cmd_a`  in  DW  first operand (dividend / radicand).
- `cmd_b`  in  DW  second operand (divisor; ignored for root).
- `mdr_load`  out  1  one-cycle operand load strobe to MDR.
- `mdr_op`  out  2  op to MDR, held for the whole transaction.
- `mdr_start`  out  1  one-cycle start strobe to MDR.
- `mdr_data`  out  DW  operand bus to MDR.
- `mdr_result`  in  DW  MDR result.
- `mdr_remainder`  in  DW  MDR remainder.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_result`  out  DW  captured result.
- `rsp_remainder`  out  DW  captured remainder.
- `rsp_err`  out  1  illegal command flag (present only with `MDR_DRV_ERR_EN`; otherwise tied 0).

## Operation
- FSM states: IDLE, LOAD_A, GAP, LOAD_B, START, WAIT, RESP.
- IDLE: `cmd_ready`=1. On `cmd_valid && cmd_ready`, register `op`, `a`, `b` and go to LOAD_A.
- LOAD_A: `mdr_load`=1, `mdr_data`=a. Go to GAP.
- GAP: `mdr_load`=0, `mdr_data` holds a. Go to LOAD_B.
- LOAD_B: `mdr_load`=1, `mdr_data`=b. For op 2, b is driven as 0. Go to START.
- START: `mdr_start`=1. Load the wait counter with WAIT_CYC-1. Go to WAIT.
- WAIT: decrement the counter. At 0, capture `mdr_result` and `mdr_remainder` into the rsp registers and go to RESP.
- RESP: `rsp_valid`=1 and rsp data stable. On `rsp_ready`, go to IDLE.
- `mdr_op` equals the registered op from LOAD_A until the return to IDLE.
- No arithmetic is done locally. Captured values are passed through unmodified and zero-width-extended to nothing.
- `cmd_valid` outside IDLE is ignored (`cmd_ready`=0).
- `rst` asserted in any state forces IDLE on the next edge and aborts any partial strobe sequence.

## Timing
- Reset values: `cmd_ready`=1, `mdr_load`=0, `mdr_start`=0, `mdr_op`=0, `mdr_data`=0, `rsp_valid`=0, `rsp_result`=0, `rsp_remainder`=0, `rsp_err`=0.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- Command accepted at edge k:
  - `mdr_load` high in cycle k+1 (A) and cycle k+3 (B).
  - `mdr_start` high in cycle k+4.
  - Capture at the end of cycle k+4+WAIT_CYC.
  - `rsp_valid` high from cycle k+5+WAIT_CYC.
- Each strobe is exactly one cycle wide. `mdr_data` is stable during each load cycle.
- Minimum command-to-command spacing is WAIT_CYC+6 cycles when `rsp_ready` is held at 1.
- `rsp_valid` stays high with stable data until `rsp_ready`. The earliest `cmd_ready` is the cycle after the handshake.

## Configuration
- `MDR_DRV_ERR_EN` defined:
  - In IDLE, op 3 or (op 1 with b==0) is accepted.
  - The MDR is not strobed; the FSM goes directly to RESP.
  - The response is `rsp_err`=1 with result=0 and remainder=0.
  - `rsp_err` clears on the response handshake.
- Not defined:
  - All commands are sequenced to the MDR unchanged and `rsp_err` is constant 0.
  - Op 3 is passed through and its outcome is undefined.

## Structure
- `Pkg_Global`: `N`; `mdr_op_e` enum (OP_MUL=0, OP_DIV=1, OP_SQRT=2, OP_RSVD=3); `drv_state_e` FSM enum.
- Single module, no sub-module. The wait counter and FSM are inline.
- Top-level integration instantiates `mdr_driver` next to `top_mdr`.

## Test plan
The bench runs with DW=8 and WAIT_CYC=10, using a behavioral MDR responder.
- Reset mid-WAIT → next cycle IDLE, all outputs at reset values, `cmd_ready`=1.
- Multiply a=7, b=3 → load strobes at k+1 and k+3 with data 7 then 3, start at k+4, `rsp_valid` at k+15, result=21, remainder=0.
- Divide a=7, b=3 → result=2, remainder=1. `mdr_op`=1 throughout the transaction.
- Root a=49 → second load data=0, result=7, remainder=0.
- `rsp_ready` held low for 5 cycles → `rsp_valid` and data stable. A `cmd_valid` pulse during that window is not accepted.
- Divide b=0 with `MDR_DRV_ERR_EN` → no `mdr_load` or `mdr_start`, `rsp_err`=1 on the cycle after acceptance. Without the macro, normal sequencing occurs.

Source files
------------

// File: rtl/mdr_driver_pkg.sv
// Shared definitions for the MDR command sequencer.
//   N           : default operand/result width
//   mdr_op_e    : operation codes understood by the MDR
//   drv_state_e : sequencer FSM states
package Pkg_Global;

    localparam int N = 8;

    typedef enum logic [1:0] {
        OP_MUL  = 2'd0,
        OP_DIV  = 2'd1,
        OP_SQRT = 2'd2,
        OP_RSVD = 2'd3
    } mdr_op_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_GAP    = 3'd2,
        S_LOAD_B = 3'd3,
        S_START  = 3'd4,
        S_WAIT   = 3'd5,
        S_RESP   = 3'd6
    } drv_state_e;

endpackage

// File: rtl/mdr_driver.sv
// mdr_driver: command-side sequencer for the multiply/divide/root unit.
// Takes one command (op, a, b) over cmd_valid/cmd_ready, strobes the
// two operands into the MDR (load A, one idle gap, load B), pulses start,
// waits WAIT_CYC cycles, captures result/remainder and returns them over
// rsp_valid/rsp_ready.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/ready/op/a/b   command handshake and operands
//   mdr_load/op/start/data   operand interface driven into the MDR
//   mdr_result/remainder     MDR outputs, sampled at the end of the wait
//   rsp_valid/ready          response handshake
//   rsp_result/remainder     captured MDR outputs
//   rsp_err                  illegal-command flag
//
// Build option: MDR_DRV_ERR_EN -- when defined, op 3 and divide-by-zero
// skip the MDR and answer immediately with rsp_err=1, result/remainder 0.
// When undefined, every command is sequenced and rsp_err is tied to 0.
//
// All outputs come from registers or state decode; none depend
// combinationally on inputs.
module mdr_driver
    import Pkg_Global::*;
#(
    parameter int DW       = N,
    parameter int WAIT_CYC = DW + 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [DW-1:0] cmd_a,
    input  logic [DW-1:0] cmd_b,
    output logic          mdr_load,
    output logic [1:0]    mdr_op,
    output logic          mdr_start,
    output logic [DW-1:0] mdr_data,
    input  logic [DW-1:0] mdr_result,
    input  logic [DW-1:0] mdr_remainder,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_result,
    output logic [DW-1:0] rsp_remainder,
    output logic          rsp_err
);

    // Counter only ever holds WAIT_CYC-1 down to 0.
    localparam int CW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

    drv_state_e    state, nxt;
    logic [1:0]    op_q;
    logic [DW-1:0] a_q, b_q;
    logic [CW-1:0] cnt;
    logic          err_cmd;

`ifdef MDR_DRV_ERR_EN
    logic err_q;
    assign err_cmd = (cmd_op == OP_RSVD) || ((cmd_op == OP_DIV) && (cmd_b == '0));
    assign rsp_err = err_q;
`else
    assign err_cmd = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:   if (cmd_valid) nxt = err_cmd ? S_RESP : S_LOAD_A;
            S_LOAD_A: nxt = S_GAP;
            S_GAP:    nxt = S_LOAD_B;
            S_LOAD_B: nxt = S_START;
            S_START:  nxt = S_WAIT;
            S_WAIT:   if (cnt == '0) nxt = S_RESP;
            S_RESP:   if (rsp_ready) nxt = S_IDLE;
            default:  nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            cnt           <= '0;
            rsp_result    <= '0;
            rsp_remainder <= '0;
`ifdef MDR_DRV_ERR_EN
            err_q         <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: if (cmd_valid) begin
                    op_q <= cmd_op;
                    a_q  <= cmd_a;
                    // Root has a single operand; the second load carries 0.
                    b_q  <= (cmd_op == OP_SQRT) ? '0 : cmd_b;
                    if (err_cmd) begin
                        rsp_result    <= '0;
                        rsp_remainder <= '0;
`ifdef MDR_DRV_ERR_EN
                        err_q         <= 1'b1;
`endif
                    end
                end
                S_START: cnt <= CW'(WAIT_CYC - 1);
                S_WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        rsp_result    <= mdr_result;
                        rsp_remainder <= mdr_remainder;
                    end
                end
`ifdef MDR_DRV_ERR_EN
                S_RESP: if (rsp_ready) err_q <= 1'b0;
`endif
                default: ;
            endcase
        end
    end

    assign cmd_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign mdr_load  = (state == S_LOAD_A) || (state == S_LOAD_B);
    assign mdr_start = (state == S_START);
    assign mdr_op    = (state == S_IDLE) ? 2'd0 : op_q;

    always_comb begin
        mdr_data = '0;
        case (state)
            S_LOAD_A, S_GAP: mdr_data = a_q;
            S_LOAD_B:        mdr_data = b_q;
            default:         mdr_data = '0;
        endcase
    end

endmodule
